// File: rtl/dio_pattern_seq_if.sv
// dio_pattern_seq_if
//   Bundles the pattern-load, playback-control and config-output signals of
//   dio_pattern_seq. The master modport drives it (host side). The slave
//   modport is the sequencer.
//
//   Handshake contract: there is no valid/ready back-pressure anywhere.
//     - wr_en is a single-cycle write request. It takes effect only while
//       busy=0. A request made while busy=1 is dropped, and wr_err pulses
//       for one cycle on the following cycle.
//     - start is level-sampled and only acted on in IDLE.
//     - abort is level-sampled, and it always wins over start.
//     - config_en is a one-cycle strobe. config_data is valid with it and
//       holds its value between strobes.
//     - done is a one-cycle pulse that appears only on normal completion.
//
//   dbg_state exposes the FSM encoding: 0=IDLE, 1=ISSUE, 2=HOLD, 3=FIN.
interface dio_pattern_seq_if #(
  parameter int ADDR_W  = 4,
  parameter int DWELL_W = 16
) ();
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [15:0]        wr_data;
  logic [ADDR_W-1:0]  last_idx;
  logic [DWELL_W-1:0] dwell;
  logic [7:0]         loop_cnt;
  logic               start;
  logic               abort;
  logic               busy;
  logic               done;
  logic               wr_err;
  logic               config_en;
  logic [15:0]        config_data;
  logic [1:0]         dbg_state;

  modport master (
    output wr_en, wr_addr, wr_data, last_idx, dwell, loop_cnt, start, abort,
    input  busy, done, wr_err, config_en, config_data, dbg_state
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, last_idx, dwell, loop_cnt, start, abort,
    output busy, done, wr_err, config_en, config_data, dbg_state
  );
endinterface

// File: rtl/dio_pattern_seq.sv
// dio_pattern_seq
//   Configuration-word sequencer that feeds the digital I/O control stage.
//   Up to DEPTH 16-bit words are loaded into a register array. On start, the
//   words in entries 0..last_idx are played out. Each word is a one-cycle
//   config_en strobe followed by `dwell` hold cycles. The pattern repeats
//   loop_cnt times, or without end when loop_cnt is 0, until it is aborted.
//
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset; also clears the pattern memory
//   bus  : dio_pattern_seq_if.slave
//          (wr_* load port, last_idx/dwell/loop_cnt run setup, start/abort,
//           busy/done/wr_err status, config_en/config_data output,
//           dbg_state FSM state)
module dio_pattern_seq #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int DWELL_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  dio_pattern_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  state_e             state_q;
  logic [15:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0]  idx_q;
  logic [ADDR_W-1:0]  last_q;
  logic [7:0]         pass_q;
  logic [7:0]         loops_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               wr_err_q;
  logic               cfg_en_q;
  logic [15:0]        cfg_data_q;

  logic               wr_ok;
  logic               at_last;
  logic               wrap_ok;
  logic               do_adv;
  logic               adv_fin;
  logic [ADDR_W-1:0]  adv_idx_d;
  logic [7:0]         adv_pass_d;
  logic [ADDR_W-1:0]  rd_addr;
  logic [15:0]        rd_word;

  always_comb begin
    wr_ok      = bus.wr_en && !busy_q;
    at_last    = (idx_q == last_q);
    wrap_ok    = (loops_q == 8'd0) || (pass_q < loops_q);
    // ISSUE advances at once when dwell is 0. Otherwise HOLD advances on the
    // cycle its counter would step from 1 to 0, so strobes stay dwell+1 apart.
    do_adv     = ((state_q == S_ISSUE) && (dwell_q == '0)) ||
                 ((state_q == S_HOLD)  && (cnt_q == DWELL_W'(1)));
    adv_fin    = at_last && !wrap_ok;
    adv_idx_d  = at_last ? '0 : idx_q + ADDR_W'(1);
    // Pass count saturates. It only matters when loop_cnt != 0, and then it
    // can never exceed loop_cnt.
    adv_pass_d = (at_last && pass_q != 8'hFF) ? pass_q + 8'd1 : pass_q;
    rd_addr    = (state_q == S_IDLE) ? '0 : adv_idx_d;
    // Forward a same-cycle idle write so a start in that cycle plays new data.
    rd_word    = (wr_ok && bus.wr_addr == rd_addr) ? bus.wr_data : mem_q[rd_addr];
  end

  // Pattern storage and write-reject flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_err_q <= 1'b0;
    end else begin
      if (wr_ok) mem_q[bus.wr_addr] <= bus.wr_data;
      wr_err_q <= bus.wr_en && busy_q;
    end
  end

  // Playback FSM. Each transition registers the outputs of the cycle it
  // enters, so config_en appears the cycle after start is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      last_q     <= '0;
      pass_q     <= 8'd0;
      loops_q    <= 8'd0;
      dwell_q    <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_en_q   <= 1'b0;
      cfg_data_q <= 16'h0000;
    end else begin
      done_q   <= 1'b0;
      cfg_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            last_q     <= bus.last_idx;
            dwell_q    <= bus.dwell;
            loops_q    <= bus.loop_cnt;
            idx_q      <= '0;
            pass_q     <= 8'd1;
            cnt_q      <= bus.dwell;
            busy_q     <= 1'b1;
            cfg_en_q   <= 1'b1;
            cfg_data_q <= rd_word;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE, S_HOLD: begin
          if (bus.abort) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (do_adv) begin
            if (adv_fin) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              idx_q      <= adv_idx_d;
              pass_q     <= adv_pass_d;
              cnt_q      <= dwell_q;
              cfg_en_q   <= 1'b1;
              cfg_data_q <= rd_word;
              state_q    <= S_ISSUE;
            end
          end else if (state_q == S_HOLD) begin
            cnt_q <= cnt_q - DWELL_W'(1);
          end else begin
            state_q <= S_HOLD;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.wr_err      = wr_err_q;
  assign bus.config_en   = cfg_en_q;
  assign bus.config_data = cfg_data_q;
  assign bus.dbg_state   = state_q;

endmodule
